// File: rtl/err_rec_sel_ctrl.sv
// Error-recovery select controller.
// On an accepted start it drives a one-hot select to a downstream product
// mux. It waits a programmable number of settle cycles and captures the
// mux output. The result is then held until the consumer takes it.
module err_rec_sel_ctrl #(
    parameter int width    = 128,
    parameter int SETTLE_W = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [2:0]            level,
    input  logic [SETTLE_W-1:0]   settle,
    input  logic [2*width-1:0]    mux_in,
    input  logic                  res_ready,
    output logic [4:0]            sel,
    output logic [2*width-1:0]    result,
    output logic                  res_valid,
    output logic                  busy,
    output logic                  level_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [SETTLE_W-1:0] CNT_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

    logic [1:0]          state_reg,     state_next;
    logic [4:0]          sel_reg,       sel_next;
    logic [SETTLE_W-1:0] cnt_reg,       cnt_next;
    logic [2*width-1:0]  result_reg,    result_next;
    logic                res_valid_reg, res_valid_next;
    logic                level_err_reg, level_err_next;

    // Levels 0..4 map onto the five mux legs. Levels 5..7 have no leg.
    // Those levels decode to all-zero and are rejected.
    logic [4:0] sel_dec;
    logic       level_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sel_dec
            assign sel_dec[gi] = (level == 3'(gi));
        end
    endgenerate

    assign level_ok = (level <= 3'd4);

    // Next-state logic. sel is loaded only on an accepted start, so it
    // always holds exactly one bit.
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        cnt_next       = cnt_reg;
        result_next    = result_reg;
        res_valid_next = res_valid_reg;
        level_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (level_ok) begin
                        sel_next   = sel_dec;
                        cnt_next   = settle;
                        state_next = ST_SETTLE;
                    end else begin
                        level_err_next = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                // The counter counts down to zero and stops there, so it
                // never wraps. The capture happens on the cycle that sees zero.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end else begin
                    result_next    = mux_in;
                    res_valid_next = 1'b1;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset aborts any operation in flight at once.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= 5'b00001;
            cnt_reg       <= '0;
            result_reg    <= '0;
            res_valid_reg <= 1'b0;
            level_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            cnt_reg       <= cnt_next;
            result_reg    <= result_next;
            res_valid_reg <= res_valid_next;
            level_err_reg <= level_err_next;
        end
    end

    assign sel       = sel_reg;
    assign result    = result_reg;
    assign res_valid = res_valid_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign level_err = level_err_reg;

endmodule

// File: tb/tb_err_rec_sel_ctrl.sv
// Self-checking bench for err_rec_sel_ctrl: directed corner cases plus
// randomized transactions against a transaction-level expectation model.
module tb_err_rec_sel_ctrl;

    localparam int W  = 128;
    localparam int SW = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        level = '0;
    logic [SW-1:0]     settle = '0;
    logic [2*W-1:0]    mux_in = '0;
    logic              res_ready = 1'b0;
    logic [4:0]        sel;
    logic [2*W-1:0]    result;
    logic              res_valid;
    logic              busy;
    logic              level_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: what sel and result must hold between transactions.
    logic [4:0]     exp_sel    = 5'b00001;
    logic [2*W-1:0] exp_result = '0;

    always #5 Clk = ~Clk;

    err_rec_sel_ctrl #(.width(W), .SETTLE_W(SW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .level     (level),
        .settle    (settle),
        .mux_in    (mux_in),
        .res_ready (res_ready),
        .sel       (sel),
        .result    (result),
        .res_valid (res_valid),
        .busy      (busy),
        .level_err (level_err)
    );

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        else
            n_pass++;
    endtask

    function automatic logic [2*W-1:0] rnd_wide();
        logic [2*W-1:0] v;
        for (int i = 0; i < (2*W)/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One start request. The capture is expected exactly stl+1 edges after
    // acceptance. The result is then held for 'hold' cycles with res_ready low.
    task automatic run_txn(input int lvl, input int stl, input int hold, input logic [2*W-1:0] cap);
        start = 1'b1; level = 3'(lvl); settle = SW'(stl);
        res_ready = 1'($urandom); mux_in = rnd_wide();
        step();
        start = 1'b0;
        if (lvl > 4) begin
            chk("err_pulse", level_err, 1);
            chk("err_busy", busy, 0);
            chk("err_sel", sel, exp_sel);
            step();
            chk("err_clear", level_err, 0);
            chk("err_result", result, exp_result);
            $display("txn lvl=%0d rejected", lvl);
            return;
        end
        exp_sel = 5'd1 << lvl;
        chk("acc_sel", sel, exp_sel);
        chk("acc_busy", busy, 1);
        chk("acc_valid", res_valid, 0);
        chk("acc_err", level_err, 0);
        for (int i = 0; i < stl; i++) begin
            mux_in = rnd_wide(); start = 1'($urandom);
            level = 3'($urandom); res_ready = 1'($urandom);
            step();
            chk("settle_valid", res_valid, 0);
            chk("settle_busy", busy, 1);
            chk("settle_sel", sel, exp_sel);
        end
        mux_in = cap; start = 1'($urandom); res_ready = 1'($urandom);
        step();
        exp_result = cap;
        chk("cap_valid", res_valid, 1);
        chk("cap_result", result, exp_result);
        chk("cap_sel", sel, exp_sel);
        for (int i = 0; i < hold; i++) begin
            mux_in = rnd_wide(); start = 1'($urandom);
            level = 3'($urandom); res_ready = 1'b0;
            step();
            chk("hold_valid", res_valid, 1);
            chk("hold_result", result, exp_result);
            chk("hold_sel", sel, exp_sel);
            chk("hold_busy", busy, 1);
        end
        res_ready = 1'b1; start = 1'($urandom); level = 3'($urandom_range(4, 0));
        step();
        res_ready = 1'b0; start = 1'b0;
        chk("rel_valid", res_valid, 0);
        chk("rel_busy", busy, 0);
        chk("rel_result", result, exp_result);
        chk("rel_sel", sel, exp_sel);
        $display("txn lvl=%0d settle=%0d hold=%0d result=%0h", lvl, stl, hold, cap);
    endtask

    // Start a level-4 operation and assert reset mid-cycle after 'cyc' edges.
    // The operation must vanish at once, without waiting for a clock edge.
    task automatic reset_mid(input int stl, input int cyc);
        start = 1'b1; level = 3'd4; settle = SW'(stl); mux_in = rnd_wide();
        step();
        start = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            mux_in = rnd_wide();
            step();
        end
        #2;
        Rst = 1'b0;
        #1;
        exp_sel = 5'b00001;
        exp_result = '0;
        chk("rst_sel", sel, exp_sel);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_result", result, exp_result);
        chk("rst_err", level_err, 0);
        #1;
        Rst = 1'b1;
        $display("txn reset abort settle=%0d after=%0d", stl, cyc);
    endtask

    initial begin
        #1 Rst = 1'b0;
        #2;
        chk("por_sel", sel, 5'b00001);
        chk("por_busy", busy, 0);
        chk("por_valid", res_valid, 0);
        chk("por_result", result, 0);
        chk("por_err", level_err, 0);
        step();
        step();
        chk("por_hold_sel", sel, 5'b00001);
        #2 Rst = 1'b1;

        // Directed corner cases.
        run_txn(2, 3, 0, 256'hABCD);
        run_txn(0, 0, 0, rnd_wide());
        run_txn(5, 0, 0, rnd_wide());
        run_txn(1, 2, 10, rnd_wide());
        reset_mid(10, 2);
        run_txn(3, 0, 1, rnd_wide());
        run_txn(4, 15, 2, rnd_wide());
        reset_mid(1, 3);
        run_txn(7, 3, 0, rnd_wide());

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(9, 0) == 0)
                reset_mid($urandom_range(15, 1), $urandom_range(3, 0));
            else
                run_txn($urandom_range(7, 0), $urandom_range(15, 0),
                        $urandom_range(4, 0), rnd_wide());
            if ($urandom_range(1, 0) == 1) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/err_rec_sel_ctrl.md
ERR_REC_SEL_CTRL -- requirements
Module: err_rec_sel_ctrl

Interface
REQ-001 SHALL have parameter width, default 128, operand width of the approximate multiplier.
REQ-002 SHALL have parameter SETTLE_W, default 4, width of the settle-count input.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port start  input  1  request to run one selection/capture cycle.
REQ-006 SHALL have port level  input  3  error-recovery level, valid 0..4, sampled on accepted start.
REQ-007 SHALL have port settle  input  SETTLE_W  cycles to hold sel before capture, sampled on accepted start.
REQ-008 SHALL have port mux_in  input  2*width  product from the downstream one-hot mux.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port sel  output  5  one-hot select driven to the mux.
REQ-011 SHALL have port result  output  2*width  captured product.
REQ-012 SHALL have port res_valid  output  1  result holds a valid, unconsumed product.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port level_err  output  1  one-cycle pulse on rejected start.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, DONE; busy = (state != IDLE).
REQ-016 In IDLE with start=1 and level<=4: sel <= 5'b00001 << level, counter <= settle, level latched, next state SETTLE.
REQ-017 In IDLE with start=1 and level>=5: level_err=1 for exactly one cycle, state stays IDLE, sel, result, counter unchanged.
REQ-018 start SHALL be ignored (no effect, no level_err) in SETTLE and DONE.
REQ-019 sel SHALL be exactly one-hot at all times, including reset, and SHALL change only on an accepted start.
REQ-020 In SETTLE with counter!=0: counter decrements by 1 per cycle.
REQ-021 In SETTLE with counter==0: result <= mux_in, res_valid <= 1, next state DONE.
REQ-022 Latency: start accepted at edge k -> sel valid after edge k -> capture at edge k+settle+1 -> res_valid high after that edge; settle=0 gives capture at edge k+1.
REQ-023 In DONE: res_valid and result held stable while res_ready=0.
REQ-024 In DONE with res_ready=1: res_valid <= 0, next state IDLE; result retains last value.
REQ-025 res_ready while res_valid=0 SHALL have no effect.
REQ-026 Next start SHALL be accepted no earlier than the cycle after returning to IDLE (no same-cycle handoff).
REQ-027 Counter SHALL never wrap; max settle (2^SETTLE_W - 1) gives 2^SETTLE_W-cycle hold.

Reset
REQ-028 Rst=0 SHALL immediately force state=IDLE, sel=5'b00001, result=0, res_valid=0, busy=0, level_err=0, counter=0.
REQ-029 Rst assertion mid-SETTLE or mid-DONE SHALL abort the operation with no capture; pending result is lost.
REQ-030 After Rst deasserts, first start SHALL be accepted on the first rising edge with Rst=1.

Verification
REQ-031 Reset then start=1, level=2, settle=3, mux_in=0xABCD -> sel=5'b00100 after edge k, res_valid rises after edge k+4, result=0xABCD.
REQ-032 start=1, level=0, settle=0, res_ready tied 1 -> capture at edge k+1, res_valid high one cycle, back in IDLE at edge k+2.
REQ-033 start=1, level=5 in IDLE -> level_err one-cycle pulse, busy=0, sel remains 5'b00001.
REQ-034 res_ready held 0 for 10 cycles in DONE while mux_in changes and start pulses -> result, sel, res_valid unchanged; then res_ready=1 -> IDLE next edge.
REQ-035 Rst=0 asserted 2 cycles into SETTLE with level=4 -> sel=5'b00001, busy=0, res_valid=0 immediately (asynchronously); no result captured.
REQ-036 level=4, settle=15 -> sel=5'b10000 held 16 cycles, capture at edge k+16, no counter wrap.
